// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle W-bit add/subtract that reuses one 4-bit ripple-carry slice per cycle,
// least-significant nibble first, with a registered carry linking the passes.

module nsa_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic axb;
    assign axb = a ^ b;
    assign s   = axb ^ ci;
    assign co  = (a & b) | (ci & axb);
endmodule

module nsa_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       c3,
    output logic       co
);
    logic [4:0] c;
    assign c[0] = ci;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        nsa_full_adder u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
    end
    assign c3 = c[3];
    assign co = c[4];
endmodule

// state | meaning
// IDLE  | waiting for start; operands latched on accept
// RUN   | one slice pass per cycle on nibble idx
// DONE  | one-cycle done pulse, results already registered
module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 carryout,
    output logic                 overflow
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    opa, opb, partial, partial_nxt;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [3:0]      slice_a, slice_b, slice_s;
    logic            slice_c3, slice_co;
    logic            last;

    nsa_slice u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry),
        .s  (slice_s),
        .c3 (slice_c3),
        .co (slice_co)
    );

    assign last = (idx == LAST);
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Nibble mux/demux around the shared slice, unrolled to keep selects constant.
    always_comb begin
        slice_a     = '0;
        slice_b     = '0;
        partial_nxt = partial;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IW'(n)) begin
                slice_a              = opa[4*n +: 4];
                slice_b              = opb[4*n +: 4];
                partial_nxt[4*n +: 4] = slice_s;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opa      <= '0;
            opb      <= '0;
            partial  <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    partial <= partial_nxt;
                    carry   <= slice_co;
                    if (last) begin
                        // Outputs only ever change on the edge entering DONE.
                        sum      <= partial_nxt;
                        carryout <= slice_co;
                        overflow <= slice_c3 ^ slice_co;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop on each done pulse.

module tb_nibble_serial_adder_ctrl;
    logic clk = 1'b0;
    always #500 clk = ~clk;

    logic        reset;
    logic        start4, sub4, busy4, done4, co4, ov4;
    logic [15:0] a4, b4, sum4;
    logic        start1, sub1, busy1, done1, co1, ov1;
    logic [3:0]  a1, b1, sum1;

    nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .sub(sub4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .carryout(co4), .overflow(ov4));

    nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .carryout(co1), .overflow(ov1));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ov;
        int          dc;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    logic [15:0] prev_sum;
    logic        prev_co, prev_ov;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (done4 === 1'b1) begin
            if (q4.size() == 0) flag("dut4 unexpected done");
            else begin
                e = q4.pop_front();
                chk("dut4 sum", sum4, e.sum);
                chk("dut4 carryout", co4, e.co);
                chk("dut4 overflow", ov4, e.ov);
                chk("dut4 done cycle", cyc, e.dc);
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (done1 === 1'b1) begin
            if (q1.size() == 0) flag("dut1 unexpected done");
            else begin
                e = q1.pop_front();
                chk("dut1 sum", sum1, e.sum);
                chk("dut1 carryout", co1, e.co);
                chk("dut1 overflow", ov1, e.ov);
                chk("dut1 done cycle", cyc, e.dc);
            end
        end
    end

    task automatic wait_idle4();
        int n = 0;
        while (busy4 !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) flag("dut4 idle timeout");
    endtask

    task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic s,
                       input logic [15:0] esum, input logic eco, input logic eov);
        int k;
        wait_idle4();
        a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        q4.push_back('{esum, eco, eov, k + 4});
        start4 = 1'b0;
        a4 = ~a; b4 = b ^ 16'h5a5a; sub4 = ~s;
        chk("dut4 busy after accept", busy4, 1);
        repeat (4) @(negedge clk);
        chk("dut4 sum held before done", sum4, prev_sum);
        chk("dut4 carryout held before done", co4, prev_co);
        chk("dut4 overflow held before done", ov4, prev_ov);
        prev_sum = esum; prev_co = eco; prev_ov = eov;
        repeat (2) @(negedge clk);
    endtask

    task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic s,
                       input logic [3:0] esum, input logic eco, input logic eov);
        int k;
        int n = 0;
        while (busy1 !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) flag("dut1 idle timeout");
        a1 = a; b1 = b; sub1 = s; start1 = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        q1.push_back('{{12'h000, esum}, eco, eov, k + 1});
        start1 = 1'b0;
        a1 = ~a; b1 = ~b; sub1 = ~s;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int k;
        int n;
        reset = 1'b1;
        start4 = 1'b1; a4 = 16'h1234; b4 = 16'h0001; sub4 = 1'b0;
        start1 = 1'b1; a1 = 4'h3; b1 = 4'h1; sub1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", busy4, 0);
        chk("reset done", done4, 0);
        chk("reset sum", sum4, 16'h0000);
        chk("reset carryout", co4, 0);
        chk("reset overflow", ov4, 0);
        chk("reset busy dut1", busy1, 0);
        reset = 1'b0; start4 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        chk("no op after reset", busy4, 0);
        prev_sum = 16'h0000; prev_co = 1'b0; prev_ov = 1'b0;

        op4(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op4(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op4(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op4(16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op4(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0);

        // start held high: accepts at k, k+6, k+12 only
        wait_idle4();
        a4 = 16'h0001; b4 = 16'h0002; sub4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        q4.push_back('{16'h0003, 1'b0, 1'b0, k + 4});
        q4.push_back('{16'h0003, 1'b0, 1'b0, k + 10});
        q4.push_back('{16'h0003, 1'b0, 1'b0, k + 16});
        while (cyc < k + 5) @(negedge clk);
        chk("held start idle gap", busy4, 0);
        while (cyc < k + 6) @(negedge clk);
        chk("held start reaccept", busy4, 1);
        while (cyc < k + 13) @(negedge clk);
        start4 = 1'b0;
        while (cyc < k + 18) @(negedge clk);
        chk("held start no extra accept", busy4, 0);
        prev_sum = 16'h0003; prev_co = 1'b0; prev_ov = 1'b0;

        // reset after two RUN cycles aborts without a done pulse
        wait_idle4();
        a4 = 16'h1234; b4 = 16'h1111; sub4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        start4 = 1'b0;
        while (cyc < k + 2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort busy", busy4, 0);
        chk("abort done", done4, 0);
        chk("abort sum", sum4, 16'h0000);
        chk("abort carryout", co4, 0);
        chk("abort overflow", ov4, 0);
        repeat (5) @(negedge clk);
        prev_sum = 16'h0000; prev_co = 1'b0; prev_ov = 1'b0;

        op4(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
        op4(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

        op1(4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b1);
        op1(4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);
        op1(4'h7, 4'h1, 1'b1, 4'h6, 1'b1, 1'b0);

        n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) flag("done never arrived for queued result");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
# nibble_serial_adder_ctrl

Multi-cycle sequencer that computes a W = 4·NIBBLES bit add or subtract by reusing a single 4-bit ripple-carry slice once per cycle, least-significant nibble first. A registered carry links each slice pass to the next. The block sits between a requester using a start/done handshake and the 4-bit adder datapath. It trades latency for area when operands are wider than the slice.

## Interface
- NIBBLES, 4, number of 4-bit slice passes; operand width W = 4·NIBBLES; legal range 1..8
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = a+b, 1 = a−b; sampled with start
- a  in  W  operand A, two's complement or unsigned; sampled with start
- b  in  W  operand B; sampled with start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; result valid
- sum  out  W  result
- carryout  out  1  carry out of MSB; for sub, 1 = no borrow
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- States:
  - **IDLE**: if start, latch a into opA and (sub ? ~b : b) into opB, set carry reg = sub, idx = 0, go to RUN. Otherwise hold.
  - **RUN**: each cycle the slice adds opA[idx], opB[idx] and carry, where [idx] is nibble idx.
    - Slice sum is written into nibble idx of the internal partial register.
    - carry ← slice cout.
    - On idx = NIBBLES−1, also capture carry-into-bit-3 of the slice for overflow, then go to DONE. Otherwise idx ← idx+1.
  - **DONE**: done = 1, then go to IDLE unconditionally.
- The 4-bit slice has a carry-in and is built from the existing gate-level full adders (AND/OR/XOR macros, 50-unit delays). Slice carry-in is driven by the carry reg, never tied to 0.
- sum, carryout and overflow are output registers:
  - Loaded only on the edge entering DONE.
  - Held stable until the next edge entering DONE.
  - They never show partial results.
- start is ignored while busy, including during the DONE cycle. A new request must be presented in IDLE.
- a, b and sub may change freely after acceptance; operands are held in opA/opB.
- Arithmetic is modulo 2^W. carryout and overflow are computed from the final slice only.
- idx width is ceil(log2(NIBBLES)), minimum 1 bit. With NIBBLES=1, RUN lasts one cycle.

## Timing
- Reset values: state IDLE, busy 0, done 0, sum 0, carryout 0, overflow 0, idx 0, carry reg 0, opA/opB/partial 0.
- Reset asserted in any state, including mid-RUN, aborts the operation:
  - Next state is IDLE and all outputs return to reset values.
  - No done pulse.
  - Reset has priority over start.
- Sequence for a start accepted at edge k:
  - busy is high from after edge k.
  - Nibble i is processed at edge k+1+i.
  - The state enters DONE at edge k+NIBBLES, and outputs update at that edge.
  - done is high from edge k+NIBBLES to edge k+NIBBLES+1.
  - busy falls after edge k+NIBBLES+1.
- Latency from start-accept edge to done: NIBBLES edges. Throughput: one operation per NIBBLES+2 cycles.
- Clock period must exceed the slice ripple path. Benches use a period of 1000 time units.

## Test plan
All scenarios use NIBBLES=4 unless stated.
- **Reset**: hold reset 2 cycles with start=1 → busy=0, done=0, sum=0x0000, carryout=0, overflow=0, no operation started.
- **Add with carry ripple**: a=0xFFFF, b=0x0001, sub=0 → done exactly 4 edges after accept; sum=0x0000, carryout=1, overflow=0; outputs unchanged before the DONE edge.
- **Signed overflow, add and subtract**:
  - a=0x7FFF+0x0001 → sum=0x8000, carryout=0, overflow=1.
  - sub: 0x8000−0x0001 → sum=0x7FFF, carryout=1, overflow=1.
  - sub: 0x0003−0x0005 → sum=0xFFFE, carryout=0, overflow=0.
- **Handshake**:
  - start held high continuously → one accept per 6 cycles; the start seen during RUN/DONE is ignored.
  - Change a/b mid-RUN → result reflects the latched operands.
- **Reset mid-operation**: assert reset after 2 RUN cycles of 0x1234+0x1111 → IDLE, outputs 0, no done. Then 0x1234+0x1111 → sum=0x2345, carryout=0, overflow=0.
- **NIBBLES=1**: 0100+0100 → sum=1000, carryout=0, overflow=1, done 1 edge after accept. 1000+1000 → sum=0000, carryout=1, overflow=1.
